zynq_tag_rx: RTL
================

# zynq_tag_rx

Serial tag receiver: the client end of the single-wire tag link that the zynq shell drives out on tag_ck/tag_data. It deserializes framed tag packets on its clock, filters them by node id, and presents either a committed payload word with a one-cycle valid pulse or a one-cycle client-reset pulse. It sits inside PL-side blocks, such as clock/reset controllers and configuration registers, that the PS programs through the tag master.

## Interface
Parameters
- node_id_p, 0: node id this client answers to
- node_id_width_p, 8: width of the node id field
- len_width_p, 5: width of the payload-length field
- data_width_p, 16: width of data_o

Ports
- clk_i  in  1  tag clock; one clock only
- reset_i  in  1  asynchronous, active-high reset
- tag_data_i  in  1  serial tag data, synchronous to clk_i
- data_o  out  data_width_p  last committed payload
- data_v_o  out  1  one-cycle pulse when data_o is updated
- client_reset_o  out  1  one-cycle pulse on a matching reset frame
- parity_err_o  out  1  one-cycle pulse on a dropped frame (parity build only)

## Operation
- Frame format, one bit per clk_i edge, every field LSB first:
  - start bit = 1
  - node id (node_id_width_p bits)
  - data_not_reset (1 bit)
  - length L (len_width_p bits)
  - L payload bits
  - optional parity bit (see Configuration)
- The line idles at 0. In IDLE, 0 bits are ignored.
- FSM states: IDLE → NODE → DNR → LEN → PAYLOAD → (PARITY) → IDLE.
  - If L=0, LEN goes directly to PARITY or IDLE.
- A single bit counter, sized max(node_id_width_p, len_width_p, data_width_p)+1, is reused per field and cleared on each state change.
- Payload capture:
  - Bit i goes to shadow bit i for i < data_width_p.
  - Bits with i ≥ data_width_p are consumed but discarded.
  - Shadow bits ≥ L are zero.
- Commit happens on the cycle after the frame ends, and only if node id == node_id_p and the parity check passes:
  - data_not_reset=1: data_o ← shadow, data_v_o=1.
  - data_not_reset=0: payload is discarded, data_o ← 0, client_reset_o=1, data_v_o=0.
- A non-matching node id consumes the whole frame, including payload and parity, with no output activity.
- Back-to-back frames: the FSM returns to IDLE in the commit cycle. A start bit sampled in that same cycle is accepted.
- Reset values: data_o=0, data_v_o=0, client_reset_o=0, parity_err_o=0, FSM=IDLE, counter=0.
- Asserting reset mid-frame aborts the frame immediately: no commit, and all outputs go to their reset values.

## Timing
- Start bit sampled at edge 0 → node id at edges 1..N, DNR at N+1, length at N+2..N+1+W, payload at the next L edges. N = node_id_width_p, W = len_width_p.
- With defaults (N=8, W=5), L=8, no parity: data_v_o is high during cycle 23, counted from the start-bit edge.
- All outputs are registered. data_o changes in the same cycle that data_v_o or client_reset_o pulses, and holds otherwise.
- Pulses are exactly one cycle wide. No handshake: the consumer must sample on the pulse.

## Configuration
- ZYNQ_TAG_RX_PARITY_EN defined:
  - An even-parity bit follows the payload. It covers node id, data_not_reset, length and payload.
  - On a mismatch, a matching frame is dropped and parity_err_o pulses in the would-be commit cycle.
  - A non-matching frame is dropped silently.
  - Commit latency is one cycle later than the no-parity build.
- ZYNQ_TAG_RX_PARITY_EN undefined:
  - No parity bit on the wire; PARITY state removed.
  - parity_err_o tied 0.

## Structure
- zynq_tag_rx_pkg holds the FSM state enum (IDLE, NODE, DNR, LEN, PAYLOAD, PARITY) and a function computing the bit-counter width from the parameters.
- One sub-module, zynq_tag_rx_deser: an LSB-first shift/capture register with bit-indexed write enable and clear. It is instantiated for the payload shadow register. Node id and length are captured in the FSM.

## Test plan
- Defaults, node_id_p=5. Frame id=5, DNR=1, L=8, payload 0xA5 → data_o=0x00A5, one data_v_o pulse in cycle 23, no other pulses.
- Frame id=6 with the same payload → no pulses, data_o unchanged. A following id=5, L=16, 0x1234 frame sent back-to-back (start bit in the commit/idle cycle) → data_o=0x1234.
- id=5, DNR=0, L=4, payload 0xF → client_reset_o pulses once, data_o=0, data_v_o stays 0.
- id=5, L=20, payload 0xABCDE → data_o=0xBCDE, one pulse. Then L=0 → data_o=0x0000, one pulse in cycle 15.
- reset_i asserted asynchronously during PAYLOAD bit 3 → outputs 0 with no clock edge needed, no commit. A fresh frame after release decodes correctly.
- ZYNQ_TAG_RX_PARITY_EN: id=5, L=8, 0x01 with a wrong parity bit → parity_err_o pulse in cycle 24, data_o unchanged. Correct parity → data_v_o in cycle 24.

Source files
------------

// File: rtl/zynq_tag_rx_pkg.sv
// Shared types and sizing helpers for the serial tag receiver.
package zynq_tag_rx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NODE    = 3'd1,
    DNR     = 3'd2,
    LEN     = 3'd3,
    PAYLOAD = 3'd4,
    PARITY  = 3'd5
  } state_e;

  // One counter is reused for every field, so it must index the widest one.
  function automatic int unsigned cnt_width(input int unsigned node_w,
                                            input int unsigned len_w,
                                            input int unsigned data_w);
    int unsigned m;
    m = node_w;
    if (len_w > m) m = len_w;
    if (data_w > m) m = data_w;
    return m + 1;
  endfunction

endpackage

// File: rtl/zynq_tag_rx_deser.sv
// LSB-first capture register: bit-indexed write, synchronous clear.
module zynq_tag_rx_deser #(
  parameter int unsigned width_p     = 16,
  parameter int unsigned idx_width_p = 17
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic [idx_width_p-1:0] idx_i,
  input  logic                   bit_i,
  output logic [width_p-1:0]     data_o
);

  logic [width_p-1:0] r_data;

  // Indices at or beyond width_p match no bit and are dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data <= '0;
    end else if (clr_i) begin
      r_data <= '0;
    end else if (we_i) begin
      for (int unsigned i = 0; i < width_p; i++) begin
        if (idx_i == idx_width_p'(i)) r_data[i] <= bit_i;
      end
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/zynq_tag_rx.sv
// Serial tag link client: deserializes, filters by node id, commits payload or reset.
// Optional trailing even-parity bit enabled by ZYNQ_TAG_RX_PARITY_EN.
module zynq_tag_rx
  import zynq_tag_rx_pkg::*;
#(
  parameter int unsigned node_id_p       = 0,
  parameter int unsigned node_id_width_p = 8,
  parameter int unsigned len_width_p     = 5,
  parameter int unsigned data_width_p    = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    tag_data_i,
  output logic [data_width_p-1:0] data_o,
  output logic                    data_v_o,
  output logic                    client_reset_o,
  output logic                    parity_err_o
);

  localparam int unsigned NW = node_id_width_p;
  localparam int unsigned LW = len_width_p;
  localparam int unsigned DW = data_width_p;
  localparam int unsigned CW = cnt_width(NW, LW, DW);

`ifdef ZYNQ_TAG_RX_PARITY_EN
  localparam state_e END_ST  = PARITY;
  localparam logic   HAS_PAR = 1'b1;
`else
  localparam state_e END_ST  = IDLE;
  localparam logic   HAS_PAR = 1'b0;
`endif

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [NW-1:0]   r_node;
  logic            r_dnr;
  logic [LW-1:0]   r_len;
  logic            r_done;
`ifdef ZYNQ_TAG_RX_PARITY_EN
  logic            r_par;
  logic            r_par_ok;
`endif

  logic [DW-1:0]   w_shadow;
  logic [NW-1:0]   w_node_nxt;
  logic [LW-1:0]   w_len_nxt;
  logic            w_match;
  logic            w_pay_last;

  // Fields arrive LSB first, so shift in from the top.
  assign w_node_nxt = {tag_data_i, r_node[NW-1:1]};
  assign w_len_nxt  = {tag_data_i, r_len[LW-1:1]};
  assign w_match    = (r_node == NW'(node_id_p));
  assign w_pay_last = ((r_cnt + CW'(1)) == CW'(r_len));

  zynq_tag_rx_deser #(
    .width_p     (DW),
    .idx_width_p (CW)
  ) u_shadow (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   ((r_state == IDLE) && tag_data_i),
    .we_i    (r_state == PAYLOAD),
    .idx_i   (r_cnt),
    .bit_i   (tag_data_i),
    .data_o  (w_shadow)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_node         <= '0;
      r_dnr          <= 1'b0;
      r_len          <= '0;
      r_done         <= 1'b0;
      data_o         <= '0;
      data_v_o       <= 1'b0;
      client_reset_o <= 1'b0;
      parity_err_o   <= 1'b0;
`ifdef ZYNQ_TAG_RX_PARITY_EN
      r_par          <= 1'b0;
      r_par_ok       <= 1'b0;
`endif
    end else begin
      data_v_o       <= 1'b0;
      client_reset_o <= 1'b0;
      parity_err_o   <= 1'b0;
      r_done         <= 1'b0;

      // Commit runs while the FSM already sits in IDLE, so a new start bit overlaps it.
      if (r_done && w_match) begin
`ifdef ZYNQ_TAG_RX_PARITY_EN
        if (!r_par_ok) parity_err_o <= 1'b1;
        else
`endif
        if (r_dnr) begin
          data_o   <= w_shadow;
          data_v_o <= 1'b1;
        end else begin
          data_o         <= '0;
          client_reset_o <= 1'b1;
        end
      end

`ifdef ZYNQ_TAG_RX_PARITY_EN
      if (r_state == IDLE) r_par <= 1'b0;
      else if (r_state != PARITY) r_par <= r_par ^ tag_data_i;
`endif

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (tag_data_i) r_state <= NODE;
        end
        NODE: begin
          r_node <= w_node_nxt;
          if (r_cnt == CW'(NW - 1)) begin
            r_cnt   <= '0;
            r_state <= DNR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DNR: begin
          r_dnr   <= tag_data_i;
          r_cnt   <= '0;
          r_state <= LEN;
        end
        LEN: begin
          r_len <= w_len_nxt;
          if (r_cnt == CW'(LW - 1)) begin
            r_cnt <= '0;
            if (w_len_nxt == '0) begin
              r_state <= END_ST;
              r_done  <= ~HAS_PAR;
            end else begin
              r_state <= PAYLOAD;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PAYLOAD: begin
          if (w_pay_last) begin
            r_cnt   <= '0;
            r_state <= END_ST;
            r_done  <= ~HAS_PAR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PARITY: begin
`ifdef ZYNQ_TAG_RX_PARITY_EN
          r_par_ok <= (r_par == tag_data_i);
`endif
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
